// File: rtl/filter_read_ptr_ctrl_pkg.sv
// Shared definitions for the filter scratchpad read path: address geometry
// and the read-pointer controller state encoding.
package filter_read_ptr_ctrl_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 256;
    localparam int CNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/filter_read_ptr_ctrl_circ_addr_incr.sv
// Combinational circular address increment: wraps DEPTH-1 back to 0.
// Also usable by the write-side pointer logic.
module filter_read_ptr_ctrl_circ_addr_incr #(
    parameter int ADDR_WIDTH = filter_read_ptr_ctrl_pkg::ADDR_WIDTH,
    parameter int DEPTH      = filter_read_ptr_ctrl_pkg::DEPTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    // Wrap at the buffer depth rather than at the address-width boundary
    always_comb begin
        next_addr = addr;
        if (addr == ADDR_WIDTH'(DEPTH - 1)) begin
            next_addr = ADDR_WIDTH'(0);
        end else begin
            next_addr = addr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/filter_read_ptr_ctrl.sv
// Read-pointer controller: walks read_addr over a circular window of the filter
// scratchpad, replaying the window once per pass, with rd_ready back-pressure.
module filter_read_ptr_ctrl
    import filter_read_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = filter_read_ptr_ctrl_pkg::ADDR_WIDTH,
    parameter int DEPTH      = filter_read_ptr_ctrl_pkg::DEPTH,
    parameter int CNT_WIDTH  = filter_read_ptr_ctrl_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_ptr_in,
    input  logic [ADDR_WIDTH-1:0] end_ptr_in,
    input  logic [CNT_WIDTH-1:0]  reuse_cnt,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] end_ptr,
    output logic                  ep_valid,
    output logic                  busy,
    output logic                  done
);

    rd_state_t             state_r;
    rd_state_t             state_nxt_s;
    logic [ADDR_WIDTH-1:0] read_addr_r;
    logic [ADDR_WIDTH-1:0] end_ptr_r;
    logic [ADDR_WIDTH-1:0] start_ptr_r;
    logic [CNT_WIDTH-1:0]  pass_r;
    logic [CNT_WIDTH-1:0]  passes_r;
    logic                  busy_r;
    logic                  done_r;
    logic [ADDR_WIDTH-1:0] addr_incr_s;
    logic                  read_en_s;
    logic                  last_elem_s;
    logic                  final_read_s;

    filter_read_ptr_ctrl_circ_addr_incr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr_incr (
        .addr      (read_addr_r),
        .next_addr (addr_incr_s)
    );

    assign read_en_s    = (state_r == ST_READ) && rd_ready;
    assign last_elem_s  = read_en_s && (read_addr_r == end_ptr_r);
    assign final_read_s = last_elem_s && (pass_r == (passes_r - CNT_WIDTH'(1)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (final_read_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Window latch, address walk and pass counting; the final read leaves read_addr on end_ptr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_addr_r <= ADDR_WIDTH'(0);
            end_ptr_r   <= ADDR_WIDTH'(0);
            start_ptr_r <= ADDR_WIDTH'(0);
            pass_r      <= CNT_WIDTH'(0);
            passes_r    <= CNT_WIDTH'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        start_ptr_r <= start_ptr_in;
                        end_ptr_r   <= end_ptr_in;
                        read_addr_r <= start_ptr_in;
                        pass_r      <= CNT_WIDTH'(0);
                        passes_r    <= (reuse_cnt == CNT_WIDTH'(0)) ? CNT_WIDTH'(1) : reuse_cnt;
                    end
                end
                ST_READ: begin
                    if (last_elem_s && !final_read_s) begin
                        read_addr_r <= start_ptr_r;
                        pass_r      <= pass_r + CNT_WIDTH'(1);
                    end else if (read_en_s && !last_elem_s) begin
                        read_addr_r <= addr_incr_s;
                    end
                end
                ST_DONE: begin
                    read_addr_r <= read_addr_r;
                end
                default: begin
                    read_addr_r <= read_addr_r;
                end
            endcase
        end
    end

    // Registered status flags, aligned with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_READ);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign read_addr = read_addr_r;
    assign end_ptr   = end_ptr_r;
    assign read_en   = read_en_s;
    assign ep_valid  = read_en_s;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_filter_read_ptr_ctrl.sv
// Scoreboard bench for filter_read_ptr_ctrl: directed jobs push expected reads
// and done pulses; a negedge monitor pops and compares as the DUT presents them.
module tb_filter_read_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_ptr_in;
    logic [7:0] end_ptr_in;
    logic [7:0] reuse_cnt;
    logic       rd_ready;
    logic [7:0] read_addr;
    logic       read_en;
    logic [7:0] end_ptr;
    logic       ep_valid;
    logic       busy;
    logic       done;

    typedef struct {
        bit         is_done;
        logic [7:0] addr;
        logic [7:0] endp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    filter_read_ptr_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_ptr_in (start_ptr_in),
        .end_ptr_in   (end_ptr_in),
        .reuse_cnt    (reuse_cnt),
        .rd_ready     (rd_ready),
        .read_addr    (read_addr),
        .read_en      (read_en),
        .end_ptr      (end_ptr),
        .ep_valid     (ep_valid),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected reads of one job, built by walking the window independently
    task automatic push_job(input int s, input int e, input int r);
        int passes;
        int a;
        passes = (r == 0) ? 1 : r;
        for (int p = 0; p < passes; p++) begin
            a = s;
            forever begin
                exp_q.push_back('{1'b0, 8'(a), 8'(e)});
                if (a == e) break;
                a = (a == 255) ? 0 : a + 1;
            end
        end
        exp_q.push_back('{1'b1, 8'd0, 8'd0});
    endtask

    // Returns one cycle after the start edge, with the DUT in READ at start_ptr
    task automatic start_pulse(input int s, input int e, input int r);
        @(posedge clk); #1;
        start        = 1'b1;
        start_ptr_in = 8'(s);
        end_ptr_in   = 8'(e);
        reuse_cnt    = 8'(r);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented read or done against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) check("no_bubble", 32'(ep_valid), 32'(rd_ready));
            if (ep_valid || done) begin
                check("ep_valid_eq_read_en", 32'(ep_valid), 32'(read_en));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got ep_valid=%0b done=%0b addr=%0d, expected nothing",
                             ep_valid, done, read_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_done) begin
                        check("done_pulse", 32'(done), 32'd1);
                        check("done_after_last_read", 32'(prev_valid), 32'd1);
                    end else begin
                        check("read_valid", 32'(ep_valid), 32'd1);
                        check("read_addr", 32'(read_addr), 32'(mon_e.addr));
                        check("end_ptr", 32'(end_ptr), 32'(mon_e.endp));
                    end
                end
            end
        end
        prev_valid <= ep_valid;
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        start_ptr_in = 8'd0;
        end_ptr_in   = 8'd0;
        reuse_cnt    = 8'd0;
        rd_ready     = 1'b1;
        #12;
        check("rst_read_addr", 32'(read_addr), 32'd0);
        check("rst_end_ptr", 32'(end_ptr), 32'd0);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic window
        push_job(2, 5, 1);
        start_pulse(2, 5, 1);
        check("busy_in_read", 32'(busy), 32'd1);
        wait_drain("job1_drain");
        check("idle_not_busy", 32'(busy), 32'd0);
        check("hold_last_addr", 32'(read_addr), 32'd5);

        // 2: window wraps through 255 -> 0
        push_job(250, 3, 1);
        start_pulse(250, 3, 1);
        wait_drain("job2_drain");

        // 3: three passes, inputs scrambled after latch
        push_job(7, 9, 3);
        start_pulse(7, 9, 3);
        start_ptr_in = 8'd100;
        end_ptr_in   = 8'd101;
        reuse_cnt    = 8'd9;
        wait_drain("job3_drain");

        // 4: stall two cycles at address 5
        push_job(4, 6, 1);
        start_pulse(4, 6, 1);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_addr", 32'(read_addr), 32'd5);
            check("stall_read_en", 32'(read_en), 32'd0);
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        wait_drain("job4_drain");

        // 5: single-entry window, reuse 0, restart held through READ and DONE
        push_job(10, 10, 0);
        start_pulse(10, 10, 0);
        start        = 1'b1;
        start_ptr_in = 8'd20;
        end_ptr_in   = 8'd21;
        reuse_cnt    = 8'd2;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("job5_drain");
        check("job5_idle", 32'(busy), 32'd0);

        // 6: reset on the third read of 0..7, then a clean rerun
        exp_q.push_back('{1'b0, 8'd0, 8'd7});
        exp_q.push_back('{1'b0, 8'd1, 8'd7});
        start_pulse(0, 7, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_addr", 32'(read_addr), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_read_addr", 32'(read_addr), 32'd0);
        check("midrst_end_ptr", 32'(end_ptr), 32'd0);
        check("midrst_read_en", 32'(ep_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        push_job(0, 7, 1);
        start_pulse(0, 7, 1);
        wait_drain("job6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
